chiplib_icg_ctrl: RTL and testbench

CHIPLIB_ICG_CTRL -- requirements
Module: chiplib_icg_ctrl

---
 rtl/chiplib_pkg.sv | 16 +
 rtl/chiplib_sat_cnt.sv | 27 ++
 rtl/chiplib_icg_ctrl.sv | 110 +++++++++++
 tb/tb_chiplib_icg_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/chiplib_pkg.sv
// Shared types and constants for the chiplib clock-gating controller.
package chiplib_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_COUNT = 2'd1,
        ST_GATED = 2'd2,
        ST_WAKE  = 2'd3
    } icg_state_e;

    localparam int WAKE_CYC_DEF = 2;
    localparam int GATE_CNT_W   = 16;
    // Holds wake_cnt for the full WAKE_CYC range 1..15.
    localparam int WAKE_CNT_W   = 4;

endpackage

// File: rtl/chiplib_sat_cnt.sv
// Saturating up-counter: increments on inc_i and sticks at all-ones.
module chiplib_sat_cnt
    import chiplib_pkg::*;
#(
    parameter int W = GATE_CNT_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/chiplib_icg_ctrl.sv
// Idle-driven clock-gate controller: counts idle cycles, drops clken, and
// re-enables with a fixed settle time before acknowledging the requester.
module chiplib_icg_ctrl
    import chiplib_pkg::*;
#(
    parameter int IDLE_W   = 8,
    parameter int WAKE_CYC = WAKE_CYC_DEF
) (
    input  logic                  clkin,
    input  logic                  rst,
    input  logic                  busy,
    input  logic                  req,
    input  logic                  force_on,
    input  logic                  test_mode,
    input  logic [IDLE_W-1:0]     idle_limit,
    output logic                  clken,
    output logic                  se_n,
    output logic                  ack,
    output logic                  gated,
    output logic [GATE_CNT_W-1:0] gate_cnt
);

    icg_state_e            state_q, state_d;
    logic [IDLE_W-1:0]     idle_cnt_q, idle_cnt_d;
    logic [WAKE_CNT_W-1:0] wake_cnt_q, wake_cnt_d;
    logic                  clken_q, ack_q, gated_q;
    logic                  wake, gate_evt;

    assign wake = busy | req | force_on | test_mode;

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        wake_cnt_d = wake_cnt_q;
        gate_evt   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (!wake && (idle_limit != '0)) begin
                    state_d    = ST_COUNT;
                    idle_cnt_d = '0;
                end
            end
            ST_COUNT: begin
                // Wake beats the gating condition when both land on one edge.
                if (wake || (idle_limit == '0)) begin
                    state_d    = ST_RUN;
                    idle_cnt_d = '0;
                end else if (idle_cnt_q >= (idle_limit - IDLE_W'(1))) begin
                    state_d    = ST_GATED;
                    idle_cnt_d = '0;
                    gate_evt   = 1'b1;
                end else begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                end
            end
            ST_GATED: begin
                if (wake) begin
                    state_d    = ST_WAKE;
                    wake_cnt_d = '0;
                end
            end
            ST_WAKE: begin
                if (wake_cnt_q == WAKE_CNT_W'(WAKE_CYC - 1)) begin
                    state_d    = ST_RUN;
                    wake_cnt_d = '0;
                end else begin
                    wake_cnt_d = wake_cnt_q + WAKE_CNT_W'(1);
                end
            end
            default: begin
                state_d    = ST_RUN;
                idle_cnt_d = '0;
                wake_cnt_d = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the state itself, with no input-to-clken combinational path.
    always_ff @(posedge clkin) begin
        if (rst) begin
            state_q    <= ST_RUN;
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
            clken_q    <= 1'b1;
            ack_q      <= 1'b1;
            gated_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            wake_cnt_q <= wake_cnt_d;
            clken_q    <= (state_d != ST_GATED);
            ack_q      <= (state_d == ST_RUN) || (state_d == ST_COUNT);
            gated_q    <= (state_d == ST_GATED);
        end
    end

    chiplib_sat_cnt #(.W(GATE_CNT_W)) u_gate_cnt (
        .clk_i (clkin),
        .rst_i (rst),
        .inc_i (gate_evt),
        .cnt_o (gate_cnt)
    );

    assign clken = clken_q;
    assign ack   = ack_q;
    assign gated = gated_q;
    assign se_n  = ~test_mode;

endmodule

// File: tb/tb_chiplib_icg_ctrl.sv
// Directed bench for chiplib_icg_ctrl with IDLE_W=8, WAKE_CYC=2, L=4.
module tb_chiplib_icg_ctrl;

    logic        clkin = 1'b0;
    logic        rst, busy, req, force_on, test_mode;
    logic [7:0]  idle_limit;
    logic        clken, se_n, ack, gated;
    logic [15:0] gate_cnt;

    int vecs = 0;
    int errs = 0;
    logic bad;

    chiplib_icg_ctrl #(.IDLE_W(8), .WAKE_CYC(2)) dut (
        .clkin      (clkin),
        .rst        (rst),
        .busy       (busy),
        .req        (req),
        .force_on   (force_on),
        .test_mode  (test_mode),
        .idle_limit (idle_limit),
        .clken      (clken),
        .se_n       (se_n),
        .ack        (ack),
        .gated      (gated),
        .gate_cnt   (gate_cnt)
    );

    always #5 clkin = ~clkin;

    // Advance n rising edges, then settle 1 time unit before driving/sampling.
    task automatic step(input int n);
        repeat (n) @(posedge clkin);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ce, input logic ak,
                           input logic gt, input logic [15:0] gc);
        chk({tag, ".clken"},    32'(clken),    32'(ce));
        chk({tag, ".ack"},      32'(ack),      32'(ak));
        chk({tag, ".gated"},    32'(gated),    32'(gt));
        chk({tag, ".gate_cnt"}, 32'(gate_cnt), 32'(gc));
    endtask

    initial begin
        rst = 1'b1; busy = 1'b1; req = 1'b0; force_on = 1'b0;
        test_mode = 1'b0; idle_limit = 8'd4;
        step(1);
        chk_out("reset", 1'b1, 1'b1, 1'b0, 16'd0);
        chk("reset.se_n", 32'(se_n), 32'd1);
        rst = 1'b0;
        step(2);

        // Idle gating: busy drops after edge N, gated from edge N+5.
        busy = 1'b0;
        step(1);
        chk_out("idle.count", 1'b1, 1'b1, 1'b0, 16'd0);
        step(3);
        chk_out("idle.last_count", 1'b1, 1'b1, 1'b0, 16'd0);
        step(1);
        chk_out("idle.gated", 1'b0, 1'b0, 1'b1, 16'd1);
        step(3);
        chk_out("idle.stay_gated", 1'b0, 1'b0, 1'b1, 16'd1);

        // Wake handshake: clken next edge, ack WAKE_CYC edges later.
        req = 1'b1;
        step(1);
        chk_out("wake.m1", 1'b1, 1'b0, 1'b0, 16'd1);
        step(1);
        chk_out("wake.m2", 1'b1, 1'b0, 1'b0, 16'd1);
        step(1);
        chk_out("wake.ack", 1'b1, 1'b1, 1'b0, 16'd1);
        req = 1'b0;
        step(4);
        chk_out("regate.before", 1'b1, 1'b1, 1'b0, 16'd1);
        step(1);
        chk_out("regate.gated", 1'b0, 1'b0, 1'b1, 16'd2);

        // Collision: busy rises exactly when idle_cnt == L-1.
        busy = 1'b1;
        step(3);
        chk_out("coll.woken", 1'b1, 1'b1, 1'b0, 16'd2);
        busy = 1'b0;
        step(4);
        busy = 1'b1;
        step(1);
        chk_out("coll.run", 1'b1, 1'b1, 1'b0, 16'd2);
        busy = 1'b0;
        step(4);
        chk_out("coll.recount", 1'b1, 1'b1, 1'b0, 16'd2);
        step(1);
        chk_out("coll.gated", 1'b0, 1'b0, 1'b1, 16'd3);

        // Overrides held for 100 cycles each.
        force_on = 1'b1;
        step(1);
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (clken !== 1'b1 || gated !== 1'b0) bad = 1'b1;
        end
        chk("force_on.hold", 32'(bad), 32'd0);
        chk("force_on.ack", 32'(ack), 32'd1);
        force_on = 1'b0; test_mode = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (clken !== 1'b1 || se_n !== 1'b0 || gated !== 1'b0) bad = 1'b1;
        end
        chk("test_mode.hold", 32'(bad), 32'd0);
        chk("test_mode.se_n", 32'(se_n), 32'd0);
        test_mode = 1'b0; idle_limit = 8'd0;
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (clken !== 1'b1 || gated !== 1'b0) bad = 1'b1;
        end
        chk("limit0.hold", 32'(bad), 32'd0);
        chk("limit0.se_n", 32'(se_n), 32'd1);
        idle_limit = 8'd4;
        step(5);
        chk_out("limit4.gated", 1'b0, 1'b0, 1'b1, 16'd4);

        // Reset mid-WAKE (wake_cnt == 1).
        req = 1'b1;
        step(2);
        chk_out("rstwake.in_wake", 1'b1, 1'b0, 1'b0, 16'd4);
        rst = 1'b1; req = 1'b0;
        step(1);
        chk_out("rstwake.reset", 1'b1, 1'b1, 1'b0, 16'd0);
        rst = 1'b0;

        // Saturation: preload FFFE, then two gate events.
        force dut.u_gate_cnt.cnt_q = 16'hFFFE;
        #1;
        release dut.u_gate_cnt.cnt_q;
        step(5);
        chk_out("sat.first", 1'b0, 1'b0, 1'b1, 16'hFFFF);
        req = 1'b1;
        step(3);
        chk_out("sat.woken", 1'b1, 1'b1, 1'b0, 16'hFFFF);
        req = 1'b0;
        step(5);
        chk_out("sat.second", 1'b0, 1'b0, 1'b1, 16'hFFFF);
        step(3);
        chk("sat.hold", 32'(gate_cnt), 32'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
